fifo_rd_burst_ctrl: RTL and testbench



---
 rtl/fifo_rd_burst_ctrl_pkg.sv | 16 +
 rtl/fifo_rd_burst_ctrl_if.sv | 35 +++
 rtl/fifo_rd_burst_ctrl_grey2bin.sv | 15 +
 rtl/fifo_rd_burst_ctrl.sv | 111 +++++++++++
 tb/tb_fifo_rd_burst_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_burst_ctrl_pkg.sv
// rtl/fifo_rd_burst_ctrl_pkg.sv - shared types and helpers for the FIFO read burst controller
// Contents: rd_state_e scheduler states, ptr_width() pointer width helper.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } rd_state_e;

    // Pointers carry one extra wrap bit above the FIFO address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_burst_ctrl_if.sv
// rtl/fifo_rd_burst_ctrl_if.sv - FIFO read-side and output-stream signals of the burst controller
// master: controller side (drives rd_inc, out_*, fifo_level, busy, burst_done)
// slave : FIFO/consumer side (drives enable, pointers, empty_flag, rd_data, out_ready)
interface fifo_rd_burst_ctrl_if
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int PW = ptr_width(ADDR_WIDTH);

    logic                  enable;
    logic [PW-1:0]         sync_grey_coded_wr_ptr;
    logic [PW-1:0]         rd_ptr_grey_coded;
    logic                  empty_flag;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_inc;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [PW-1:0]         fifo_level;
    logic                  busy;
    logic                  burst_done;

    modport master (
        input  enable, sync_grey_coded_wr_ptr, rd_ptr_grey_coded, empty_flag, rd_data, out_ready,
        output rd_inc, out_data, out_valid, fifo_level, busy, burst_done
    );

    modport slave (
        output enable, sync_grey_coded_wr_ptr, rd_ptr_grey_coded, empty_flag, rd_data, out_ready,
        input  rd_inc, out_data, out_valid, fifo_level, busy, burst_done
    );

endinterface

// File: rtl/fifo_rd_burst_ctrl_grey2bin.sv
// rtl/fifo_rd_burst_ctrl_grey2bin.sv - gray to binary pointer converter
// Ports: grey (in, WIDTH) gray-coded value; bin (out, WIDTH) binary equivalent.
module grey2bin_conv #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] grey,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^grey[WIDTH-1:i];
    end

endmodule

// File: rtl/fifo_rd_burst_ctrl.sv
// rtl/fifo_rd_burst_ctrl.sv - read-domain burst scheduler for the async FIFO
// Ports: rd_clk, rd_rst_n (async active-low); bus (master modport): enable, gray
// write/read pointers, empty_flag, rd_data in; rd_inc pop strobe, registered
// out_data/out_valid with out_ready, fifo_level, busy, burst_done out.
module fifo_rd_burst_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_LEN   = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                rd_clk,
    input  logic                rd_rst_n,
    fifo_rd_burst_ctrl_if.master bus
);

    localparam int PW = ptr_width(ADDR_WIDTH);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [PW-1:0] BURST_LEN_P = PW'(BURST_LEN);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 1);

    rd_state_e             state;
    logic [PW-1:0]         wr_bin;
    logic [PW-1:0]         rd_bin;
    logic [PW-1:0]         level;
    logic [PW-1:0]         burst_cnt;
    logic [TW-1:0]         tmo_cnt;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  burst_done_q;
    logic                  pop;

    grey2bin_conv #(.WIDTH(PW)) u_wr_g2b (.grey(bus.sync_grey_coded_wr_ptr), .bin(wr_bin));
    grey2bin_conv #(.WIDTH(PW)) u_rd_g2b (.grey(bus.rd_ptr_grey_coded),      .bin(rd_bin));

    // Modulo subtract absorbs pointer wrap; the extra pointer bit lets a full FIFO read as 2^ADDR_WIDTH.
    assign level = wr_bin - rd_bin;

    // Pop only when the output register is free or being drained this cycle,
    // so a stalled consumer never causes a word to be overwritten.
    assign pop = (state == BURST) && !bus.empty_flag &&
                 (!out_valid_q || bus.out_ready) && (burst_cnt != '0);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state        <= IDLE;
            burst_cnt    <= '0;
            tmo_cnt      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            burst_done_q <= 1'b0;
        end else begin
            burst_done_q <= 1'b0;

            if (pop) begin
                out_data_q  <= bus.rd_data;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (bus.enable) state <= WAIT;
                end
                WAIT: begin
                    if (!bus.enable) begin
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else if (level >= BURST_LEN_P) begin
                        burst_cnt <= BURST_LEN_P;
                        tmo_cnt   <= '0;
                        state     <= BURST;
                    end else if (level != '0) begin
                        // Partial burst: flush whatever is there once the timeout expires.
                        if (tmo_cnt == TMO_LAST) begin
                            burst_cnt <= level;
                            tmo_cnt   <= '0;
                            state     <= BURST;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end else begin
                        tmo_cnt <= '0;
                    end
                end
                BURST: begin
                    // enable is ignored here so a started burst always completes.
                    if (pop) begin
                        burst_cnt <= burst_cnt - 1'b1;
                        if (burst_cnt == PW'(1)) begin
                            burst_done_q <= 1'b1;
                            state        <= WAIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_inc     = pop;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.fifo_level = level;
    assign bus.busy       = (state == BURST);
    assign bus.burst_done = burst_done_q;

endmodule

// File: tb/tb_fifo_rd_burst_ctrl.sv
// tb/tb_fifo_rd_burst_ctrl.sv - self-checking bench for fifo_rd_burst_ctrl
module tb_fifo_rd_burst_ctrl;
    import fifo_ctrl_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int PW = AW + 1;

    logic rd_clk = 1'b0;
    logic rd_rst_n;
    always #5 rd_clk = ~rd_clk;

    fifo_rd_burst_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fifo_rd_burst_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(4), .TIMEOUT_CYC(16)
    ) dut (
        .rd_clk  (rd_clk),
        .rd_rst_n(rd_rst_n),
        .bus     (bus)
    );

    // Behavioural FIFO storage; read pointer = rd_off + number of pops seen.
    logic [DW-1:0] mem [16];
    logic [PW-1:0] wr_bin = '0;
    logic [PW-1:0] rd_off = '0;
    logic [PW-1:0] pops   = '0;
    logic [PW-1:0] rd_bin;
    logic          empty_force = 1'b0;
    logic [DW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign rd_bin                     = rd_off + pops;
    assign bus.sync_grey_coded_wr_ptr = b2g(wr_bin);
    assign bus.rd_ptr_grey_coded      = b2g(rd_bin);
    assign bus.empty_flag             = (wr_bin == rd_bin) || empty_force;
    assign bus.rd_data                = mem[rd_bin[AW-1:0]];

    always @(posedge rd_clk) if (bus.rd_inc) pops <= pops + 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output word is compared against the scoreboard queue.
    always @(negedge rd_clk) begin
        if (rd_rst_n === 1'b1) begin
            if (bus.burst_done) done_seen++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", bus.out_data);
                end else begin
                    check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wr_bin[AW-1:0]] = d;
        wr_bin = wr_bin + 1'b1;
        exp_q.push_back(d);
    endtask

    task automatic wait_busy(input string name, input int exp_cycles);
        int n = 0;
        while (!bus.busy && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(n), 32'(exp_cycles));
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((bus.busy || bus.out_valid) && n < 60) begin
            tick();
            n++;
        end
        check({name, "_idle"}, 32'(bus.busy || bus.out_valid), 32'(0));
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [PW-1:0] p0;
        int d0;
        int bad;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rd_rst_n      = 1'b0;
        bus.enable    = 1'b1;
        bus.out_ready = 1'b1;
        #2;
        // 1: reset state
        check("rst_out_valid",  32'(bus.out_valid),  32'(0));
        check("rst_rd_inc",     32'(bus.rd_inc),     32'(0));
        check("rst_out_data",   32'(bus.out_data),   32'(0));
        check("rst_burst_done", 32'(bus.burst_done), 32'(0));
        check("rst_busy",       32'(bus.busy),       32'(0));
        repeat (2) @(posedge rd_clk);
        #1 rd_rst_n = 1'b1;
        tick();
        check("t1_state_wait", 32'(dut.state),      32'(WAIT));
        check("t1_level",      32'(bus.fifo_level), 32'(0));
        check("t1_rd_inc",     32'(bus.rd_inc),     32'(0));

        // 2: full burst of four, back-to-back
        d0 = done_seen;
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        #1;
        check("t2_level", 32'(bus.fifo_level), 32'(4));
        wait_busy("t2_latency", 1);
        for (int i = 0; i < 4; i++) begin
            check("t2_rd_inc", 32'(bus.rd_inc), 32'(1));
            tick();
        end
        check("t2_rd_inc_end", 32'(bus.rd_inc),     32'(0));
        check("t2_burst_done", 32'(bus.burst_done), 32'(1));
        check("t2_busy_end",   32'(bus.busy),       32'(0));
        tick();
        check("t2_done_width", 32'(bus.burst_done), 32'(0));
        drain("t2");
        check("t2_done_count", 32'(done_seen - d0), 32'(1));

        // 3: partial flush after 16 WAIT cycles, then timeout restarts from 0
        push(8'hB0);
        push(8'hB1);
        #1;
        check("t3_level", 32'(bus.fifo_level), 32'(2));
        wait_busy("t3_timeout", 16);
        check("t3_rd_inc0", 32'(bus.rd_inc), 32'(1));
        tick();
        check("t3_rd_inc1", 32'(bus.rd_inc), 32'(1));
        tick();
        check("t3_rd_inc_end", 32'(bus.rd_inc),     32'(0));
        check("t3_burst_done", 32'(bus.burst_done), 32'(1));
        drain("t3");
        push(8'hC0);
        #1;
        wait_busy("t3_timeout_again", 16);
        tick();
        check("t3_single_done", 32'(bus.burst_done), 32'(1));
        drain("t3b");

        // 4: consumer stall mid-burst
        p0 = pops;
        d0 = done_seen;
        for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i));
        #1;
        wait_busy("t4_latency", 1);
        tick();
        bus.out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_rd_inc",   32'(bus.rd_inc),   32'(0));
            check("t4_stall_out_data", 32'(bus.out_data), 32'(8'hD0));
            check("t4_stall_busy",     32'(bus.busy),     32'(1));
            tick();
        end
        bus.out_ready = 1'b1;
        drain("t4");
        check("t4_pop_count",  32'(PW'(pops - p0)), 32'(4));
        check("t4_done_count", 32'(done_seen - d0), 32'(1));

        // empty_flag raised while in BURST: pops stall, state holds
        empty_force = 1'b1;
        for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i));
        #1;
        wait_busy("te_latency", 1);
        for (int i = 0; i < 3; i++) begin
            check("te_stall_rd_inc", 32'(bus.rd_inc), 32'(0));
            tick();
        end
        check("te_busy_held", 32'(bus.busy), 32'(1));
        empty_force = 1'b0;
        #1;
        check("te_resume_rd_inc", 32'(bus.rd_inc), 32'(1));
        drain("te");

        // 5: pointer wrap-around, rd binary 30 -> wr binary 2
        rd_off = PW'(30) - pops;
        wr_bin = PW'(30);
        for (int i = 0; i < 4; i++) push(8'hF0 + 8'(i));
        #1;
        check("t5_level", 32'(bus.fifo_level), 32'(4));
        d0 = done_seen;
        wait_busy("t5_latency", 1);
        drain("t5");
        check("t5_done_count", 32'(done_seen - d0), 32'(1));

        // 6: reset mid-burst after 2 of 4 pops
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
        #1;
        wait_busy("t6_latency", 1);
        tick();
        tick();
        bus.enable = 1'b0;
        rd_rst_n   = 1'b0;
        #1;
        check("t6_rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("t6_rst_rd_inc",    32'(bus.rd_inc),    32'(0));
        check("t6_rst_busy",      32'(bus.busy),      32'(0));
        check("t6_rst_out_data",  32'(bus.out_data),  32'(0));
        exp_q.delete();
        tick();
        tick();
        rd_rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.rd_inc || bus.busy || bus.out_valid) bad++;
        end
        check("t6_idle_activity", 32'(bad),            32'(0));
        check("t6_state_idle",    32'(dut.state),      32'(IDLE));
        check("t6_level_kept",    32'(bus.fifo_level), 32'(2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
